// File: rtl/risc16_sequencer.sv
// risc16_sequencer: multi-cycle fetch/decode/execute/writeback controller for the RISC_16 datapath
module risc16_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [15:0] alu_out,
  output logic [3:0]  reg_a,
  output logic [3:0]  reg_b,
  output logic [7:0]  imm8,
  output logic        reg_r_enable,
  output logic        reg_w_enable,
  output logic        alu_mux,
  output logic        sign_mux,
  output logic        w_data_mux,
  output logic        disp_enable,
  output logic [2:0]  pc_enables,
  output logic [3:0]  alu_op,
  output logic [1:0]  state,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  state_t cs, ns;
  logic [15:0] ir;
  logic        z;
  logic [3:0]  op;
  logic        active, wb, r_type, addi, disp, beqz, jmp, bad;
  assign op     = ir[15:12];
  assign r_type = (op != 4'h0) && !op[3];
  assign addi   = op == 4'h8;
  assign disp   = op == 4'hA;
  assign beqz   = op == 4'hB;
  assign jmp    = op == 4'hC;
  assign bad    = (op == 4'h9) || (op == 4'hD) || (op == 4'hE);
  always_ff @(posedge clk) begin
    if (rst) begin
      cs      <= S_IDLE;
      ir      <= '0;
      z       <= 1'b0;
      illegal <= 1'b0;
    end else begin
      cs <= ns;
      if (cs == S_FETCH && imem_ack) ir <= imem_data;
      if (cs == S_EXEC) z <= alu_out == 16'h0000;
      if (cs == S_DECODE && bad) illegal <= 1'b1;
    end
  end
  always_comb begin
    ns = cs;
    unique case (cs)
      S_IDLE:   ns = enable ? S_FETCH : S_IDLE;
      S_FETCH:  ns = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: ns = S_EXEC;
      S_EXEC:   ns = (op == 4'hF) ? S_HALT : S_WB;
      S_WB:     ns = enable ? S_FETCH : S_IDLE;
      S_HALT:   ns = S_HALT;
      default:  ns = S_IDLE;
    endcase
  end
  // Decoded controls are only driven while an instruction is in flight
  assign active       = (cs == S_DECODE) || (cs == S_EXEC) || (cs == S_WB);
  assign wb           = cs == S_WB;
  assign reg_a        = active ? ir[11:8] : 4'h0;
  assign reg_b        = active ? ir[7:4] : 4'h0;
  assign imm8         = active ? ir[7:0] : 8'h00;
  assign alu_op       = !active ? 4'h0 : r_type ? op : (addi || disp || beqz) ? 4'h1 : 4'h0;
  assign alu_mux      = active && (addi || disp || beqz);
  assign sign_mux     = active && addi;
  assign reg_r_enable = (cs == S_DECODE) || (cs == S_EXEC);
  assign reg_w_enable = wb && (r_type || addi);
  assign disp_enable  = wb && disp;
  assign pc_enables   = !wb ? 3'b000 : (beqz && z) ? 3'b100 : jmp ? 3'b001 : 3'b010;
  assign w_data_mux   = 1'b0;
  assign imem_req     = cs == S_FETCH;
  assign halted       = cs == S_HALT;
  assign state        = (cs == S_IDLE) ? 2'd0 : (cs == S_FETCH) ? 2'd1 : (cs == S_DECODE) ? 2'd2 : 2'd3;
endmodule

// File: tb/tb_risc16_sequencer.sv
// tb_risc16_sequencer: scoreboard bench; expected writeback controls queued per fetch, compared on the WB cycle
module tb_risc16_sequencer;
  logic        clk = 0, rst = 1, enable = 0, imem_ack = 0;
  logic [15:0] imem_data = '0, alu_out = '0;
  logic        imem_req, reg_r_enable, reg_w_enable, alu_mux, sign_mux, w_data_mux, disp_enable, halted, illegal;
  logic [3:0]  reg_a, reg_b, alu_op;
  logic [7:0]  imm8;
  logic [2:0]  pc_enables;
  logic [1:0]  state;
  typedef struct packed {
    logic [2:0] pc;
    logic       w;
    logic       d;
    logic [3:0] ra;
    logic [7:0] imm;
    logic [3:0] aop;
    logic       am;
    logic       sm;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, req_cnt = 0, w_cnt = 0;
  risc16_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_data(imem_data), .alu_out(alu_out), .reg_a(reg_a), .reg_b(reg_b), .imm8(imm8),
    .reg_r_enable(reg_r_enable), .reg_w_enable(reg_w_enable), .alu_mux(alu_mux),
    .sign_mux(sign_mux), .w_data_mux(w_data_mux), .disp_enable(disp_enable),
    .pc_enables(pc_enables), .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] ins, input logic zero);
    exp_t e;
    logic [3:0] o;
    o = ins[15:12];
    e.pc  = (o == 4'hB && zero) ? 3'b100 : (o == 4'hC) ? 3'b001 : 3'b010;
    e.w   = (o >= 4'h1 && o <= 4'h8);
    e.d   = o == 4'hA;
    e.ra  = ins[11:8];
    e.imm = ins[7:0];
    e.am  = (o == 4'h8 || o == 4'hA || o == 4'hB);
    e.aop = (o >= 4'h1 && o <= 4'h7) ? o : e.am ? 4'h1 : 4'h0;
    e.sm  = o == 4'h8;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t o, e;
    if (imem_req) req_cnt++;
    if (reg_w_enable) w_cnt++;
    if ((reg_w_enable || disp_enable) && pc_enables == 3'b000) chk("strobe_without_pc", 32'(pc_enables), 32'h7);
    if (!rst && pc_enables != 3'b000) begin
      o = {pc_enables, reg_w_enable, disp_enable, reg_a, imm8, alu_op, alu_mux, sign_mux};
      if (sb.size() == 0) chk("unexpected_wb", 32'(o), 32'h0);
      else begin
        e = sb.pop_front();
        chk("wb_controls", 32'(o), 32'(e));
      end
    end
  end
  task automatic run(input logic [15:0] ins, input int dly, input logic [15:0] av, input logic en_after);
    int n = 0, r0, w0;
    exp_t e;
    e = model(ins, av == 16'h0);
    if (ins[15:12] != 4'hF) sb.push_back(e);
    while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin chk("req_timeout", 32'(imem_req), 32'h1); return; end
    r0 = req_cnt;
    w0 = w_cnt;
    repeat (dly) begin @(posedge clk); #1; end
    imem_data = ins; imem_ack = 1; alu_out = av;
    @(posedge clk); #1 imem_ack = 0;
    chk("dec_state", 32'(state), 32'h2);
    chk("dec_imm8", 32'(imm8), 32'(ins[7:0]));
    enable = en_after;
    @(posedge clk); #1;
    chk("exe_state", 32'(state), 32'h3);
    @(posedge clk); #1 alu_out = (av == 16'h0) ? 16'h0001 : 16'h0000;
    @(posedge clk); #1;
    chk("req_cycles", 32'(req_cnt - r0), 32'(dly + 1));
    chk("w_strobes", 32'(w_cnt - w0), 32'(e.w && ins[15:12] != 4'hF));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_outs", 32'({imem_req, reg_r_enable, reg_w_enable, disp_enable, pc_enables, halted, illegal}), 32'h0);
    rst = 0; enable = 1;
    @(posedge clk); #1;
    chk("fetch_req", 32'(imem_req), 32'h1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_fetch_req", 32'(imem_req), 32'h0);
    chk("rst_fetch_state", 32'(state), 32'h0);
    rst = 0; enable = 0; imem_ack = 1; imem_data = 16'h8305;
    repeat (2) @(posedge clk);
    #1 imem_ack = 0;
    chk("stray_ack_state", 32'(state), 32'h0);
    enable = 1;
    run(16'h8305, 0, 16'h0007, 1);
    run(16'h2345, 3, 16'h0003, 1);
    run(16'hB2FE, 0, 16'h0000, 1);
    run(16'hB2FE, 1, 16'h0001, 1);
    run(16'hA700, 0, 16'h0004, 1);
    run(16'hC040, 2, 16'h0000, 1);
    run(16'hD123, 0, 16'h0000, 1);
    chk("illegal_set", 32'(illegal), 32'h1);
    run(16'h0000, 0, 16'h0005, 1);
    chk("illegal_sticky", 32'(illegal), 32'h1);
    run(16'h7123, 0, 16'h0009, 0);
    chk("idle_after_disable", 32'(state), 32'h0);
    enable = 1;
    @(posedge clk); #1;
    chk("refetch_state", 32'(state), 32'h1);
    run(16'hF000, 0, 16'h0000, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("halted", 32'(halted), 32'h1);
    chk("halt_state", 32'(state), 32'h3);
    chk("halt_strobes", 32'({imem_req, reg_r_enable, reg_w_enable, disp_enable, pc_enables, reg_a, imm8, alu_op}), 32'h0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
